// File: rtl/inst_fetch_unit.sv
// Instruction fetch and length pre-decode stage. Reads an instruction one
// byte at a time from byte-wide memory, resolves its length from the opcode
// (and ModRM where needed) and presents the bytes plus num_of_ope to the
// EIP register.
//
// Memory handshake: mem_req is the request/valid side and mem_ack is the
// response/ready side. A byte transfers on every rising edge where both are
// high. mem_addr is held stable while mem_req is high and mem_ack is low.
// mem_req may stay high across back-to-back transfers, and mem_addr advances
// on the transfer edge. mem_req never rises for a byte beyond the resolved
// length.
module inst_fetch_unit #(
  parameter int ADDR_W    = 32,
  parameter int MAX_BYTES = 6
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   start,
  input  logic [ADDR_W-1:0]      eip,
  output logic                   mem_req,
  output logic [ADDR_W-1:0]      mem_addr,
  input  logic                   mem_ack,
  input  logic [7:0]             mem_rdata,
  output logic [8*MAX_BYTES-1:0] inst_bytes,
  output logic [3:0]             num_of_ope,
  output logic                   inst_valid,
  output logic                   illegal,
  output logic                   busy,
  output logic [1:0]             fsm_state
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_REQ    = 2'd1,
    S_DECODE = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  state_t                 state_q, state_d;
  logic [ADDR_W-1:0]      base_q;
  logic [3:0]             count_q;
  logic [3:0]             len_q;       // 0 while the length is still unresolved
  logic                   ill_pend_q;  // illegal verdict, published in DECODE
  logic [8*MAX_BYTES-1:0] inst_bytes_q;
  logic [3:0]             num_q;
  logic                   valid_q;
  logic                   illegal_q;

  logic       start_ok;
  logic       xfer;
  logic [3:0] res_len;
  logic       res_ill;
  logic [3:0] count_inc;
  logic       last_byte;

  // Opcode table: returns {illegal, length}; length 0 means a ModRM byte is needed.
  function automatic logic [4:0] decode_opcode(input logic [7:0] op);
    logic [4:0] r;
    r = {1'b1, 4'd1};
    case (op) inside
      8'h90, [8'h40:8'h5F], 8'hC3, 8'hF4:                      r = {1'b0, 4'd1};
      8'hEB, 8'h74, 8'h75:                                     r = {1'b0, 4'd2};
      [8'hB8:8'hBF], 8'hE8, 8'hE9:                             r = {1'b0, 4'd5};
      8'h89, 8'h8B, 8'h01, 8'h29, 8'h31, 8'h39, 8'h83, 8'hC7: r = {1'b0, 4'd0};
      default:                                                 r = {1'b1, 4'd1};
    endcase
    return r;
  endfunction

  // ModRM table: only register-direct (mod = 11) forms are supported.
  function automatic logic [4:0] decode_modrm(input logic [7:0] op, input logic [7:0] modrm);
    logic [4:0] r;
    if (modrm[7:6] != 2'b11) begin
      r = {1'b1, 4'd2};
    end else begin
      case (op)
        8'h83:   r = {1'b0, 4'd3};
        8'hC7:   r = {1'b0, 4'd6};
        default: r = {1'b0, 4'd2};
      endcase
    end
    return r;
  endfunction

  assign start_ok = start && ((state_q == S_IDLE) || (state_q == S_DONE));
  assign xfer     = (state_q == S_REQ) && mem_ack;

  // Resolve the length from the byte arriving on this transfer, so that the
  // request can drop on the same edge as the final byte (no speculative reads).
  always_comb begin
    res_len = len_q;
    res_ill = ill_pend_q;
    if (count_q == 4'd0) begin
      {res_ill, res_len} = decode_opcode(mem_rdata);
    end else if ((count_q == 4'd1) && (len_q == 4'd0)) begin
      {res_ill, res_len} = decode_modrm(inst_bytes_q[7:0], mem_rdata);
    end
    count_inc = count_q + 4'd1;
    last_byte = (count_inc == res_len) || (count_inc == 4'(MAX_BYTES));
  end

  // Next-state logic for the fetch FSM.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (start_ok) state_d = S_REQ;
      S_REQ:    if (xfer && last_byte) state_d = S_DECODE;
      S_DECODE: state_d = S_DONE;
      S_DONE:   if (start_ok) state_d = S_REQ;
      default:  state_d = S_IDLE;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // Datapath: capture on start, collect bytes on transfers, publish in DECODE.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      base_q       <= '0;
      count_q      <= '0;
      len_q        <= '0;
      ill_pend_q   <= 1'b0;
      inst_bytes_q <= '0;
      num_q        <= '0;
      valid_q      <= 1'b0;
      illegal_q    <= 1'b0;
    end else if (start_ok) begin
      base_q       <= eip;
      count_q      <= '0;
      len_q        <= '0;
      ill_pend_q   <= 1'b0;
      inst_bytes_q <= '0;
      num_q        <= '0;
      valid_q      <= 1'b0;
      illegal_q    <= 1'b0;
    end else if (xfer) begin
      for (int k = 0; k < MAX_BYTES; k++) begin
        if (int'(count_q) == k) inst_bytes_q[8*k +: 8] <= mem_rdata;
      end
      count_q    <= count_inc;
      len_q      <= res_len;
      ill_pend_q <= res_ill;
    end else if (state_q == S_DECODE) begin
      num_q     <= len_q;
      valid_q   <= 1'b1;
      illegal_q <= ill_pend_q;
    end
  end

  assign mem_req    = (state_q == S_REQ);
  assign mem_addr   = mem_req ? (base_q + {{(ADDR_W-4){1'b0}}, count_q}) : '0;
  assign busy       = (state_q == S_REQ) || (state_q == S_DECODE);
  assign inst_bytes = inst_bytes_q;
  assign num_of_ope = num_q;
  assign inst_valid = valid_q;
  assign illegal    = illegal_q;
  assign fsm_state  = state_q;

endmodule

// File: tb/tb_inst_fetch_unit.sv
// Bench for inst_fetch_unit: table of directed instructions, reset and
// busy-start corner sequences, then random instructions against a
// rule-level length model.
module tb_inst_fetch_unit;

  logic        clock;
  logic        reset;
  logic        start;
  logic [31:0] eip;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ack;
  logic [7:0]  mem_rdata;
  logic [47:0] inst_bytes;
  logic [3:0]  num_of_ope;
  logic        inst_valid;
  logic        illegal;
  logic        busy;
  logic [1:0]  fsm_state;

  inst_fetch_unit #(.ADDR_W(32), .MAX_BYTES(6)) dut (
    .clock      (clock),
    .reset      (reset),
    .start      (start),
    .eip        (eip),
    .mem_req    (mem_req),
    .mem_addr   (mem_addr),
    .mem_ack    (mem_ack),
    .mem_rdata  (mem_rdata),
    .inst_bytes (inst_bytes),
    .num_of_ope (num_of_ope),
    .inst_valid (inst_valid),
    .illegal    (illegal),
    .busy       (busy),
    .fsm_state  (fsm_state)
  );

  // ---------------- clock / reset ----------------
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // ---------------- memory responder + scoreboard state ----------------
  logic [7:0]  mem [logic [31:0]];
  logic [31:0] addr_q [$];
  logic [31:0] exp_q [$];
  int          ack_wait;
  int          ack_count;
  int          stab_err;
  bit          late_ack;
  int          n_cmp;
  int          n_fail;

  initial begin
    int          wcnt;
    logic [31:0] held;
    wcnt      = 0;
    held      = '0;
    mem_ack   = 1'b0;
    mem_rdata = 8'h00;
    forever begin
      @(negedge clock);
      if (reset) begin
        mem_ack = 1'b0;
        wcnt    = 0;
      end else if (late_ack) begin
        mem_ack   = 1'b1;
        mem_rdata = 8'h5A;
      end else if (mem_req) begin
        if (wcnt == 0) held = mem_addr;
        else if (mem_addr != held) stab_err++;
        if (wcnt >= ack_wait) begin
          mem_ack   = 1'b1;
          mem_rdata = mem.exists(mem_addr) ? mem[mem_addr] : 8'h00;
          addr_q.push_back(mem_addr);
          ack_count++;
          wcnt = 0;
        end else begin
          mem_ack = 1'b0;
          wcnt++;
        end
      end else begin
        mem_ack = 1'b0;
        wcnt    = 0;
      end
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  // Length and legality straight from the instruction-set rules.
  function automatic void ref_decode(input logic [47:0] img, output int len, output bit ill);
    logic [7:0] op;
    logic [7:0] modrm;
    op    = img[7:0];
    modrm = img[15:8];
    ill   = 1'b0;
    if (op inside {8'h90, [8'h40:8'h5F], 8'hC3, 8'hF4}) len = 1;
    else if (op inside {8'hEB, 8'h74, 8'h75}) len = 2;
    else if (op inside {[8'hB8:8'hBF], 8'hE8, 8'hE9}) len = 5;
    else if (op inside {8'h89, 8'h8B, 8'h01, 8'h29, 8'h31, 8'h39, 8'h83, 8'hC7}) begin
      if (modrm[7:6] != 2'b11) begin
        len = 2;
        ill = 1'b1;
      end else if (op == 8'h83) len = 3;
      else if (op == 8'hC7) len = 6;
      else len = 2;
    end else begin
      len = 1;
      ill = 1'b1;
    end
  endfunction

  // ---------------- driver: one complete fetch ----------------
  task automatic run_fetch(input string name, input logic [31:0] addr, input logic [47:0] img,
                           input int wt, input int exp_len, input bit exp_ill, input bit glitch);
    logic [47:0] exp_bytes;
    logic [31:0] a;
    int          cyc;
    bit          done;
    int          acks_at_done;
    for (int k = 0; k < 6; k++) mem[addr + 32'(k)] = img[8*k +: 8];
    exp_bytes = '0;
    exp_q.delete();
    for (int k = 0; k < exp_len; k++) begin
      exp_bytes[8*k +: 8] = img[8*k +: 8];
      exp_q.push_back(addr + 32'(k));
    end
    ack_wait  = wt;
    ack_count = 0;
    stab_err  = 0;
    addr_q.delete();

    @(negedge clock);
    eip   = addr;
    start = 1'b1;
    @(posedge clock);
    #1 start = 1'b0;
    cyc  = 0;
    done = 1'b0;
    while (!done && cyc < 200) begin
      @(posedge clock);
      #1;
      cyc++;
      if (glitch && cyc == 2) begin
        start = 1'b1;
        eip   = 32'h0000_0700;
      end else begin
        start = 1'b0;
      end
      if (inst_valid) done = 1'b1;
    end
    start = 1'b0;
    check({name, " completed"}, 64'(done), 64'd1);
    check({name, " latency"}, 64'(cyc), 64'(exp_len * (wt + 1) + 1));
    check({name, " num_of_ope"}, 64'(num_of_ope), 64'(exp_len));
    check({name, " illegal"}, 64'(illegal), 64'(exp_ill));
    check({name, " inst_bytes"}, 64'(inst_bytes), 64'(exp_bytes));
    check({name, " acks"}, 64'(ack_count), 64'(exp_len));
    check({name, " addr stable"}, 64'(stab_err), 64'd0);
    while (exp_q.size() > 0) begin
      a = exp_q.pop_front();
      if (addr_q.size() > 0) check({name, " addr"}, 64'(addr_q.pop_front()), 64'(a));
      else check({name, " addr missing"}, 64'(addr_q.size()), 64'd1);
    end
    check({name, " extra reads"}, 64'(addr_q.size()), 64'd0);
    // DONE holds its outputs and never issues another request.
    acks_at_done = ack_count;
    repeat (3) @(posedge clock);
    #1;
    check({name, " hold valid"}, 64'(inst_valid), 64'd1);
    check({name, " hold len"}, 64'(num_of_ope), 64'(exp_len));
    check({name, " no req in done"}, 64'({mem_req, busy}), 64'd0);
    check({name, " no more acks"}, 64'(ack_count), 64'(acks_at_done));
  endtask

  // ---------------- directed table ----------------
  typedef struct {
    string       name;
    logic [31:0] addr;
    logic [47:0] img;
    int          wt;
    int          len;
    bit          ill;
    logic [47:0] bytes;
  } vec_t;

  vec_t vecs [8];

  logic [7:0] ops [24];

  initial begin
    int          len;
    bit          ill;
    int          r;
    logic [31:0] ra;
    logic [47:0] img;
    logic [7:0]  op;
    logic [7:0]  modrm;

    n_cmp    = 0;
    n_fail   = 0;
    late_ack = 1'b0;
    ack_wait = 0;
    ack_count = 0;
    stab_err = 0;
    reset    = 1'b1;
    start    = 1'b0;
    eip      = '0;

    vecs[0] = '{"nop",       32'h0000_0041, 48'hEEDDCCBBAA90, 0, 1, 1'b0, 48'h000000000090};
    vecs[1] = '{"mov_imm",   32'h0000_0100, 48'hAA12345678B8, 0, 5, 1'b0, 48'h0012345678B8};
    vecs[2] = '{"mov_rm32",  32'h0000_0200, 48'h00000001C0C7, 3, 6, 1'b0, 48'h00000001C0C7};
    vecs[3] = '{"mov_mem",   32'h0000_0300, 48'h1122334405_89, 0, 2, 1'b1, 48'h000000000589};
    vecs[4] = '{"bad_op",    32'h0000_0380, 48'h11223344550F, 0, 1, 1'b1, 48'h00000000000F};
    vecs[5] = '{"wrap",      32'hFFFF_FFFE, 48'hAABBCC07C083, 1, 3, 1'b0, 48'h00000007C083};
    vecs[6] = '{"jmp_short", 32'h0000_0400, 48'h55443322_10EB, 0, 2, 1'b0, 48'h0000000010EB};
    vecs[7] = '{"sub_rr",    32'h0000_0500, 48'h99887766C829, 2, 2, 1'b0, 48'h00000000C829};

    ops = '{8'h90, 8'h40, 8'h4F, 8'h50, 8'h5F, 8'hC3, 8'hF4, 8'hEB, 8'h74, 8'h75,
            8'hB8, 8'hBF, 8'hE8, 8'hE9, 8'h89, 8'h8B, 8'h01, 8'h29, 8'h31, 8'h39,
            8'h83, 8'hC7, 8'h0F, 8'hFF};

    // Reset state.
    repeat (2) @(posedge clock);
    #1;
    check("reset outputs", 64'({mem_req, inst_valid, illegal, busy, num_of_ope}), 64'd0);
    check("reset addr", 64'(mem_addr), 64'd0);
    check("reset bytes", 64'(inst_bytes), 64'd0);
    @(negedge clock);
    reset = 1'b0;

    // Directed vectors, cross-checked against the model as well.
    for (int i = 0; i < 8; i++) begin
      ref_decode(vecs[i].img, len, ill);
      check({vecs[i].name, " model len"}, 64'(len), 64'(vecs[i].len));
      run_fetch(vecs[i].name, vecs[i].addr, vecs[i].img, vecs[i].wt, vecs[i].len, vecs[i].ill, 1'b0);
    end

    // start while busy must not move the base address.
    run_fetch("busy_start", 32'h0000_0100, 48'hAA12345678B8, 1, 5, 1'b0, 1'b1);

    // Reset during the second ack wait of a 5-byte fetch.
    for (int k = 0; k < 6; k++) mem[32'h600 + 32'(k)] = 8'(8'hB8 + 8'(k));
    ack_wait  = 3;
    ack_count = 0;
    @(negedge clock);
    eip   = 32'h0000_0600;
    start = 1'b1;
    @(posedge clock);
    #1 start = 1'b0;
    r = 0;
    while (ack_count < 1 && r < 50) begin
      @(posedge clock);
      #1;
      r++;
    end
    check("rst first ack seen", 64'(ack_count), 64'd1);
    @(negedge clock);
    @(negedge clock);
    #2 reset = 1'b1;
    #1;
    check("rst mid mem_req", 64'(mem_req), 64'd0);
    check("rst mid busy", 64'(busy), 64'd0);
    check("rst mid num", 64'(num_of_ope), 64'd0);
    check("rst mid bytes", 64'(inst_bytes), 64'd0);
    @(posedge clock);
    #1 reset = 1'b0;
    late_ack = 1'b1;
    @(posedge clock);
    #1 late_ack = 1'b0;
    @(posedge clock);
    #1;
    check("late ack ignored", 64'({mem_req, busy, inst_valid, illegal}), 64'd0);
    check("late ack bytes", 64'(inst_bytes), 64'd0);
    run_fetch("after_reset", 32'h0000_0041, 48'hEEDDCCBBAA90, 0, 1, 1'b0, 1'b0);

    // Random instructions against the model.
    for (int i = 0; i < 40; i++) begin
      ra = $urandom;
      r  = $urandom_range(0, 3);
      op = (r == 0) ? 8'($urandom_range(0, 255)) : ops[$urandom_range(0, 23)];
      modrm = ($urandom_range(0, 2) != 0) ? {2'b11, 6'($urandom_range(0, 63))}
                                          : 8'($urandom_range(0, 255));
      img = {$urandom, modrm, op};
      ref_decode(img, len, ill);
      run_fetch($sformatf("rand%0d", i), ra, img, $urandom_range(0, 2), len, ill, 1'b0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/inst_fetch_unit.md
Name: inst_fetch_unit

Overview:
- Instruction fetch and length pre-decode stage; sits directly upstream of the EIP register.
- On a start pulse it latches the current eip and reads instruction bytes one at a time from byte-wide memory over a req/ack handshake.
- It decodes the instruction length from the opcode and, where needed, the ModRM byte.
- It presents the assembled instruction bytes plus num_of_ope (length 1..6). The EIP register uses num_of_ope for its post-instruction increment.

Parameters:
- ADDR_W, 32, width of eip and mem_addr.
- MAX_BYTES, 6, maximum instruction length; width of inst_bytes is 8*MAX_BYTES.

Ports:
- clock  input  1  single system clock; all state changes on rising edge.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  one-cycle request to fetch the instruction at eip; honoured only in IDLE or DONE.
- eip  input  ADDR_W  current instruction pointer; sampled on the accepted start edge.
- mem_req  output  1  memory read request.
- mem_addr  output  ADDR_W  byte address of the current read.
- mem_ack  input  1  memory has valid data on mem_rdata this cycle.
- mem_rdata  input  8  read byte.
- inst_bytes  output  48  fetched bytes; byte k at [8k+7:8k]; unfetched bytes are 0.
- num_of_ope  output  4  decoded instruction length, 1..6; 0 when not valid.
- inst_valid  output  1  high in DONE; inst_bytes and num_of_ope are stable while high.
- illegal  output  1  opcode/ModRM not in the supported table; valid together with inst_valid.
- busy  output  1  high in REQ and DECODE.

Behaviour:
- Reset (async, immediate), all outputs 0:
  - mem_req, mem_addr, inst_bytes, num_of_ope, inst_valid, illegal, busy are 0.
  - Internal base address, byte count and length are 0; state = IDLE.
  - Reset mid-fetch drops mem_req without waiting for ack; a late ack after reset is ignored.
- States:
  - IDLE -> REQ on start: base <= eip; count <= 0; inst_bytes <= 0; inst_valid <= 0; illegal <= 0; num_of_ope <= 0.
  - REQ: mem_req = 1; mem_addr = base + count, mod 2^ADDR_W (0xFFFFFFFF + 1 wraps to 0). mem_addr is held stable until mem_ack is sampled high.
  - On a rising edge with mem_req and mem_ack both high:
    - inst_bytes[8*count +: 8] <= mem_rdata; count <= count + 1.
    - mem_req may stay high back-to-back; mem_addr advances on the same edge.
  - Length resolution after byte 0 (opcode), registered:
    - 0x90, 0x40-0x4F, 0x50-0x5F, 0xC3, 0xF4: length 1.
    - 0xEB, 0x74, 0x75: length 2.
    - 0xB8-0xBF, 0xE8, 0xE9: length 5.
    - 0x89, 0x8B, 0x01, 0x29, 0x31, 0x39, 0x83, 0xC7: need ModRM; fetch byte 1, then resolve.
    - Any other opcode: length 1, illegal <= 1.
  - ModRM resolution, after byte 1; only mod = 11 is supported:
    - 0x89/0x8B/0x01/0x29/0x31/0x39: length 2.
    - 0x83: length 3.
    - 0xC7: length 6.
    - mod != 11: length 2, illegal <= 1, stop fetching.
  - When count == resolved length: REQ -> DONE. mem_req <= 0; num_of_ope <= length; inst_valid <= 1.
  - DONE: outputs are held. start -> same actions as IDLE start. DONE is never left without start.
- Timing:
  - start is ignored while busy.
  - mem_req rises on the edge after accepting start.
  - A 1-byte instruction with zero-wait ack completes in 2 cycles from start to inst_valid.
  - Each extra byte adds 1 cycle at zero wait, plus the ack wait cycles.
- Limits:
  - Never more than MAX_BYTES reads per instruction.
  - num_of_ope is never greater than 6.
  - No speculative reads beyond the resolved length.
- Simultaneous start and reset: reset wins.

Test Plan:
- Reset then eip = 0x41, start; memory[0x41] = 0x90, zero-wait ack -> one read at 0x41; num_of_ope = 1; inst_bytes = 0x000000000090; inst_valid 2 cycles after start; illegal = 0.
- eip = 0x100; bytes B8 78 56 34 12 -> addresses 0x100..0x104 read in order; num_of_ope = 5; inst_bytes = 0x001234567 8B8 (i.e. 0x0012345678B8); exactly 5 acks consumed.
- eip = 0x200; bytes C7 C0 01 00 00 00; ack delayed 3 cycles per byte -> mem_addr stable during each wait; num_of_ope = 6; no 7th request.
- eip = 0x300; bytes 89 05 -> num_of_ope = 2, illegal = 1; opcode 0x0F -> num_of_ope = 1, illegal = 1.
- eip = 0xFFFFFFFE; bytes 83 C0 07 -> mem_addr sequence 0xFFFFFFFE, 0xFFFFFFFF, 0x00000000; num_of_ope = 3.
- Assert reset during the 2nd ack wait of a 5-byte fetch -> mem_req, busy and num_of_ope go 0 immediately; later ack is ignored; the next start fetches cleanly. start pulsed while busy -> ignored; base address unchanged.
